// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared definitions for the fetch-side branch predictor:
//               2-bit saturating counter encodings, default table index
//               width and the sequential PC increment.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

  // Counter encoding: MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  localparam int          DEFAULT_INDEX_BITS = 4;
  localparam logic [31:0] PC_INCR            = 32'd4;

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Bundles the fetch lookup, EX resolution, redirect and
//               statistics signals of the branch predictor.
// Ports       : master - pipeline side (drives IF/EX, observes outputs)
//               slave  - predictor side
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;

  // Fetch-stage lookup
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  // EX-stage resolution
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  // Redirect to the PC mux
  logic        mispredict;
  logic [31:0] correct_pc;

  // Statistics
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  modport master (
    output if_pc, ex_valid, ex_branch, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, correct_pc,
           branch_count, mispred_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, correct_pc,
           branch_count, mispred_count
  );

endinterface : branch_predictor_if
`default_nettype wire

// File: rtl/branch_predictor_sat_counter_2bit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_sat_counter_2bit
// Description : Combinational next state of a 2-bit saturating counter.
//               Taken moves toward ST, not-taken toward SNT; both ends hold.
// Ports       : ctr_i   - current counter state
//               taken_i - resolved outcome
//               ctr_o   - next counter state
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_sat_counter_2bit
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule : branch_predictor_sat_counter_2bit
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped table of 2-bit saturating counters with tag,
//               valid and target fields. Predicts taken/target for the fetch
//               PC combinationally, trains on the EX resolution, and issues a
//               registered one-cycle mispredict redirect.
// Ports       : clk_i  - system clock (CLK), rising edge
//               rst_ni - asynchronous active-low reset (RESET)
//               bp     - slave side of branch_predictor_if (IF lookup, EX
//                        resolution, redirect, branch/mispredict counts)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  ctr_e                ctr_q    [ENTRIES];

  // --------------------------------------------------------------------------
  // Lookup (reads the registered table, so a same-cycle EX update to the
  // same entry is only seen from the next cycle)
  // --------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;

  assign if_idx = bp.if_pc[INDEX_BITS+1:2];
  assign if_tag = bp.if_pc[31:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign bp.pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : (bp.if_pc + PC_INCR);

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  ctr_e                  ctr_trained;

  assign ex_idx = bp.ex_pc[INDEX_BITS+1:2];
  assign ex_tag = bp.ex_pc[31:INDEX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  branch_predictor_sat_counter_2bit u_sat_counter (
    .ctr_i   (ctr_q[ex_idx]),
    .taken_i (bp.ex_taken),
    .ctr_o   (ctr_trained)
  );

  logic                entry_we;
  logic                entry_valid_d;
  logic [TAG_BITS-1:0] entry_tag_d;
  logic [31:0]         entry_target_d;
  ctr_e                entry_ctr_d;

  always_comb begin
    entry_we       = 1'b0;
    entry_valid_d  = valid_q[ex_idx];
    entry_tag_d    = tag_q[ex_idx];
    entry_target_d = target_q[ex_idx];
    entry_ctr_d    = ctr_q[ex_idx];
    if (bp.ex_valid) begin
      if (bp.ex_branch) begin
        if (ex_hit) begin
          entry_we    = 1'b1;
          entry_ctr_d = ctr_trained;
          // Rewriting on every taken resolution keeps JALR targets current.
          if (bp.ex_taken) begin
            entry_target_d = bp.ex_target;
          end
        end else if (bp.ex_taken) begin
          entry_we       = 1'b1;
          entry_valid_d  = 1'b1;
          entry_tag_d    = ex_tag;
          entry_target_d = bp.ex_target;
          entry_ctr_d    = CTR_WT;
        end
      end else if (ex_hit) begin
        // A non-branch matched an entry: the entry is stale, drop it.
        entry_we      = 1'b1;
        entry_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (entry_we) begin
      valid_q[ex_idx]  <= entry_valid_d;
      tag_q[ex_idx]    <= entry_tag_d;
      target_q[ex_idx] <= entry_target_d;
      ctr_q[ex_idx]    <= entry_ctr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Mispredict detection, redirect and statistics
  // --------------------------------------------------------------------------
  logic        mp;
  logic        mispredict_q;
  logic [31:0] correct_pc_q;
  logic [31:0] correct_pc_d;
  logic [31:0] branch_count_q;
  logic [31:0] branch_count_d;
  logic [31:0] mispred_count_q;
  logic [31:0] mispred_count_d;

  always_comb begin
    mp = 1'b0;
    if (bp.ex_valid) begin
      if (bp.ex_branch) begin
        mp = (bp.ex_taken != bp.ex_pred_taken) ||
             (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));
      end else begin
        mp = bp.ex_pred_taken;
      end
    end
  end

  always_comb begin
    correct_pc_d    = correct_pc_q;
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (mp) begin
      correct_pc_d    = (bp.ex_branch && bp.ex_taken) ? bp.ex_target
                                                      : (bp.ex_pc + PC_INCR);
      mispred_count_d = mispred_count_q + 32'd1;
    end
    if (bp.ex_valid && bp.ex_branch) begin
      branch_count_d = branch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispredict_q    <= 1'b0;
      correct_pc_q    <= 32'h0;
      branch_count_q  <= 32'h0;
      mispred_count_q <= 32'h0;
    end else begin
      mispredict_q    <= mp;
      correct_pc_q    <= correct_pc_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bp.mispredict    = mispredict_q;
  assign bp.correct_pc    = correct_pc_q;
  assign bp.branch_count  = branch_count_q;
  assign bp.mispred_count = mispred_count_q;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. A driver issues
//               directed and random IF/EX traffic, and a reference model of
//               the predictor table pushes the expected per-cycle outputs into
//               a scoreboard queue that a separate monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int IB = 4;
  localparam int NE = 16;

  logic clk;
  logic rst_n;

  branch_predictor_if bp ();

  branch_predictor dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bp     (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one record per table slot, counter as an integer 0..3
  // --------------------------------------------------------------------------
  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  bit          m_mp;
  logic [31:0] m_cpc, m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'h0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_mp  = 1'b0;
    m_cpc = 32'h0;
    m_bc  = 32'h0;
    m_mc  = 32'h0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  typedef struct {
    logic        ptk;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] cpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb_q[$];

  // One clock of traffic: drive, record expectations, advance the model.
  task automatic step(input logic [31:0] ifpc, input logic v, input logic br, input logic tk,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    exp_t e;
    int   i;
    bit   hit;
    bit   mp;
    @(posedge clk);
    #1;
    bp.if_pc          = ifpc;
    bp.ex_valid       = v;
    bp.ex_branch      = br;
    bp.ex_taken       = tk;
    bp.ex_pc          = pc;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = ptk;
    bp.ex_pred_target = ptgt;

    model_pred(ifpc, e.ptk, e.ptgt);
    e.mp  = m_mp;
    e.cpc = m_cpc;
    e.bc  = m_bc;
    e.mc  = m_mc;
    sb_q.push_back(e);

    if (!v)      mp = 1'b0;
    else if (br) mp = (tk != ptk) || (tk && (tgt != ptgt));
    else         mp = ptk;
    m_mp = mp;
    if (mp) begin
      m_cpc = (br && tk) ? tgt : pc + 32'd4;
      m_mc  = m_mc + 32'd1;
    end
    if (v && br) m_bc = m_bc + 32'd1;

    if (v) begin
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      if (br && hit) begin
        m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                      : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (tk) m_tgt[i] = tgt;
      end else if (br && tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(pc);
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end else if (!br && hit) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(ifpc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares DUT outputs against the scoreboard each cycle
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pred_taken",    {31'h0, bp.pred_taken}, {31'h0, e.ptk});
      chk("pred_target",   bp.pred_target,         e.ptgt);
      chk("mispredict",    {31'h0, bp.mispredict}, {31'h0, e.mp});
      if (e.mp) chk("correct_pc", bp.correct_pc, e.cpc);
      chk("branch_count",  bp.branch_count,        e.bc);
      chk("mispred_count", bp.mispred_count,       e.mc);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] pool [8];

  initial begin
    logic        rtk;
    logic [31:0] rtgt;
    logic [31:0] rpc;
    logic        rbr, rv, rtaken, rptk;
    logic [31:0] rptgt, rtg;

    pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h200; pool[3] = 32'h300;
    pool[4] = 32'h400; pool[5] = 32'h80;  pool[6] = 32'h0;   pool[7] = 32'hFFFFFFFC;

    rst_n             = 1'b0;
    bp.if_pc          = 32'h0;
    bp.ex_valid       = 1'b0;
    bp.ex_branch      = 1'b0;
    bp.ex_taken       = 1'b0;
    bp.ex_pc          = 32'h0;
    bp.ex_target      = 32'h0;
    bp.ex_pred_taken  = 1'b0;
    bp.ex_pred_target = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state seen through the lookup
    idle(32'h100);

    // Taken branch allocates at WT and redirects to its target
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    idle(32'h100);

    // Two not-takens from WT (both carried taken), then two more saturate
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80);
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 1, 32'h80);
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 0, 32'h104);
    step(32'h100, 1, 1, 0, 32'h100, 32'h80, 0, 32'h104);
    idle(32'h100);
    // From SNT one taken gives WNT, a second gives WT
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    idle(32'h100);

    // Non-branch sharing the index, then one matching the tag
    step(32'h100, 1, 0, 0, 32'h140, 32'h0, 1, 32'h80);
    idle(32'h100);
    step(32'h100, 1, 0, 0, 32'h100, 32'h0, 1, 32'h80);
    idle(32'h100);

    // JALR with a changing target
    step(32'h200, 1, 1, 1, 32'h200, 32'h300, 0, 32'h204);
    step(32'h200, 1, 1, 1, 32'h200, 32'h400, 1, 32'h300);
    idle(32'h200);
    step(32'h200, 1, 1, 1, 32'h200, 32'h400, 1, 32'h400);
    idle(32'h200);

    // PC+4 wraps at the top of the address space
    step(32'hFFFFFFFC, 1, 1, 0, 32'hFFFFFFFC, 32'h40, 1, 32'h40);
    idle(32'hFFFFFFFC);

    // Random traffic over a small PC space so entries hit and alias
    for (int n = 0; n < 400; n++) begin
      rpc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : (32'($urandom_range(0, 127)) << 2);
      rv     = ($urandom_range(0, 3) != 0);
      rbr    = ($urandom_range(0, 2) != 0);
      rtaken = rbr && $urandom_range(0, 1);
      rtg    = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : (32'($urandom_range(0, 127)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        model_pred(rpc, rptk, rptgt);
      end else begin
        rptk  = 1'($urandom_range(0, 1));
        rptgt = rptk ? rtg : rpc + 32'd4;
      end
      rtk  = 1'b0;
      rtgt = 32'h0;
      step(($urandom_range(0, 1) == 1) ? rpc : (32'($urandom_range(0, 127)) << 2),
           rv, rbr, rtaken, rpc, rtg, rptk, rptgt);
    end
    idle(32'h100);

    // Train 0x100, then reset while a mispredicting instruction is in EX
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 1, 32'h80);
    idle(32'h100);
    idle(32'h100);
    @(posedge clk);
    #1;
    bp.if_pc          = 32'h100;
    bp.ex_valid       = 1'b1;
    bp.ex_branch      = 1'b1;
    bp.ex_taken       = 1'b1;
    bp.ex_pc          = 32'h100;
    bp.ex_target      = 32'h500;
    bp.ex_pred_taken  = 1'b0;
    bp.ex_pred_target = 32'h104;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    chk("rst mispredict",    {31'h0, bp.mispredict}, 32'h0);
    chk("rst pred_taken",    {31'h0, bp.pred_taken}, 32'h0);
    chk("rst pred_target",   bp.pred_target,         32'h104);
    chk("rst correct_pc",    bp.correct_pc,          32'h0);
    chk("rst branch_count",  bp.branch_count,        32'h0);
    chk("rst mispred_count", bp.mispred_count,       32'h0);
    bp.ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table is empty again after reset
    idle(32'h100);
    idle(32'h100);
    step(32'h100, 1, 1, 1, 32'h100, 32'h80, 0, 32'h104);
    idle(32'h100);
    idle(32'h100);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
